clocks_reset_seq: RTL and testbench

//  Reset sequencer directly downstream of the clocks PLL. Runs on the free-running 50 MHz

---
 rtl/clocks_rst_pkg.sv | 12 +
 rtl/clocks_sync2.sv | 23 ++
 rtl/clocks_reset_seq.sv | 133 +++++++++++++
 tb/tb_clocks_reset_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clocks_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package clocks_rst_pkg;

    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN} rst_state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/clocks_sync2.sv
// Two-flop synchronizer, async active-high reset to 0; two refclk cycles of latency.
module clocks_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clocks_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, filters lock, then releases domain resets in index order.
// Optional lock_loss_cnt output when CLOCKS_RST_LOSS_CNT_EN is defined.
module clocks_reset_seq
    import clocks_rst_pkg::*;
#(
    parameter int NUM_RST        = 4,
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_FILTER    = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int RELOCK_TIMEOUT = 1048576
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               soft_rst_req,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rst_out,
`ifdef CLOCKS_RST_LOSS_CNT_EN
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
`endif
    output logic               ready
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
    localparam int MAX_B = (STAGE_GAP > RELOCK_TIMEOUT) ? STAGE_GAP : RELOCK_TIMEOUT;
    localparam int CW    = cnt_w((MAX_A > MAX_B) ? MAX_A : MAX_B);
    localparam int FW    = cnt_w(LOCK_FILTER);
    localparam logic [NUM_RST-1:0] LAST_STAGE = NUM_RST'(1) << (NUM_RST - 1);

    rst_state_t         state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [FW-1:0]      filt, filt_nxt;
    logic               pll_rst_nxt, ready_nxt;
    logic [NUM_RST-1:0] rst_out_nxt;
    logic               lk_s;

    clocks_sync2 #(.W(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lk_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state   <= PLL_RST;
            cnt     <= '0;
            filt    <= '0;
            pll_rst <= 1'b1;
            rst_out <= '1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            filt    <= filt_nxt;
            pll_rst <= pll_rst_nxt;
            rst_out <= rst_out_nxt;
            ready   <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        filt_nxt    = '0;
        pll_rst_nxt = 1'b0;
        rst_out_nxt = rst_out;
        ready_nxt   = ready;
        case (state)
            PLL_RST: begin
                pll_rst_nxt = 1'b1;
                rst_out_nxt = '1;
                ready_nxt   = 1'b0;
                if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                    state_nxt   = WAIT_LOCK;
                    pll_rst_nxt = 1'b0;
                end
            end
            WAIT_LOCK: begin
                filt_nxt = lk_s ? filt + 1'b1 : '0;
                // A completed filter takes priority over a timeout in the same cycle
                if (lk_s && filt == FW'(LOCK_FILTER - 1)) begin
                    state_nxt = RELEASE;
                end else if (cnt == CW'(RELOCK_TIMEOUT - 1)) begin
                    state_nxt   = PLL_RST;
                    pll_rst_nxt = 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (!lk_s) begin
                    state_nxt   = PLL_RST;
                    pll_rst_nxt = 1'b1;
                    rst_out_nxt = '1;
                    ready_nxt   = 1'b0;
                end else if (soft_rst_req) begin
                    state_nxt   = RELEASE;
                    rst_out_nxt = '1;
                    ready_nxt   = 1'b0;
                    cnt_nxt     = '0;
                end else if (state == RELEASE && cnt == CW'(STAGE_GAP - 1)) begin
                    // Shifting zeros in from bit 0 releases domains strictly in index order
                    cnt_nxt     = '0;
                    rst_out_nxt = rst_out << 1;
                    if (rst_out == LAST_STAGE) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = PLL_RST;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

`ifdef CLOCKS_RST_LOSS_CNT_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_q;

    // Covers both lock loss from RELEASE/RUN and a WAIT_LOCK timeout
    assign loss_evt = (state_nxt == PLL_RST) && (state != PLL_RST);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_evt && loss_q != '1) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_clocks_reset_seq.sv
// Bench for clocks_reset_seq: timestamp-based reference model, per-cycle compare, directed pins, random traffic.
module tb_clocks_reset_seq;

    localparam int NR  = 4;
    localparam int PRC = 4;
    localparam int LF  = 8;
    localparam int SG  = 4;
    localparam int RT  = 64;

    localparam int M_PLL  = 0;
    localparam int M_WAIT = 1;
    localparam int M_REL  = 2;
    localparam int M_RUN  = 3;

    logic          refclk = 1'b0;
    logic          rst = 1'b0;
    logic          locked = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic          pll_rst;
    logic [NR-1:0] rst_out;
    logic          ready;
`ifdef CLOCKS_RST_LOSS_CNT_EN
    logic [7:0]    lock_loss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 refclk = ~refclk;

    clocks_reset_seq #(
        .NUM_RST        (NR),
        .PLL_RST_CYCLES (PRC),
        .LOCK_FILTER    (LF),
        .STAGE_GAP      (SG),
        .RELOCK_TIMEOUT (RT)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .locked        (locked),
        .soft_rst_req  (soft_rst_req),
        .pll_rst       (pll_rst),
        .rst_out       (rst_out),
`ifdef CLOCKS_RST_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .ready         (ready)
    );

    // Reference model: k = edges since reset, t = edge at which the current phase began.
    int            k, t, mode, consec, loss;
    bit            hist[$];
    bit            lks;
    logic          m_pll, m_ready;
    logic [NR-1:0] m_rst_out;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            k = 0; t = 0; mode = M_PLL; consec = 0; loss = 0;
            hist = {1'b0, 1'b0};
        end else begin
            k++;
            lks = hist.pop_front();
            hist.push_back(locked);
            case (mode)
                M_PLL: if (k - t == PRC) begin mode = M_WAIT; t = k; consec = 0; end
                M_WAIT: begin
                    consec = lks ? consec + 1 : 0;
                    if (consec == LF) begin mode = M_REL; t = k; end
                    else if (k - t == RT) begin mode = M_PLL; t = k; if (loss < 255) loss++; end
                end
                default: begin
                    if (!lks) begin mode = M_PLL; t = k; if (loss < 255) loss++; end
                    else if (soft_rst_req) begin mode = M_REL; t = k; end
                    else if (mode == M_REL && k - t == SG * NR) begin mode = M_RUN; t = k; end
                end
            endcase
        end
        m_pll   = (mode == M_PLL);
        m_ready = (mode == M_RUN);
        if (mode == M_REL)      m_rst_out = {NR{1'b1}} << ((k - t) / SG);
        else if (mode == M_RUN) m_rst_out = '0;
        else                    m_rst_out = '1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    always @(negedge refclk) begin
        if (!rst) begin
            check("cyc_pll_rst", 32'(pll_rst), 32'(m_pll));
            check("cyc_rst_out", 32'(rst_out), 32'(m_rst_out));
            check("cyc_ready", 32'(ready), 32'(m_ready));
`ifdef CLOCKS_RST_LOSS_CNT_EN
            check("cyc_loss_cnt", 32'(lock_loss_cnt), 32'(loss));
`endif
        end
    end

    task automatic wait_k(input int n);
        while (k < n) @(negedge refclk);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_rst_out"}, 32'(rst_out), 32'hF);
        check({tag, "_ready"}, 32'(ready), 32'd0);
`ifdef CLOCKS_RST_LOSS_CNT_EN
        check({tag, "_loss_cnt"}, 32'(lock_loss_cnt), 32'd0);
`endif
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_rst_out", 32'(rst_out), 32'hF);
        check("rst_ready", 32'(ready), 32'd0);
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;

        // Power-up
        wait_k(3);   check("pu_pll_hi", 32'(pll_rst), 32'd1);
        wait_k(4);   check("pu_pll_lo", 32'(pll_rst), 32'd0);
        wait_k(10);  locked = 1'b1;
        wait_k(23);  check("pu_r23", 32'(rst_out), 32'hF);
        wait_k(24);  check("pu_r24", 32'(rst_out), 32'hE);
        wait_k(28);  check("pu_r28", 32'(rst_out), 32'hC);
        wait_k(32);  check("pu_r32", 32'(rst_out), 32'h8);
        wait_k(35);  check("pu_rdy35", 32'(ready), 32'd0);
        wait_k(36);  check("pu_r36", 32'(rst_out), 32'h0);
                     check("pu_rdy36", 32'(ready), 32'd1);

        // Soft reset in RUN
        wait_k(40);  soft_rst_req = 1'b1;
        wait_k(41);  soft_rst_req = 1'b0;
                     check("sr_r41", 32'(rst_out), 32'hF);
                     check("sr_pll41", 32'(pll_rst), 32'd0);
        wait_k(44);  check("sr_r44", 32'(rst_out), 32'hF);
        wait_k(45);  check("sr_r45", 32'(rst_out), 32'hE);
        wait_k(49);  check("sr_r49", 32'(rst_out), 32'hC);
        wait_k(53);  check("sr_r53", 32'(rst_out), 32'h8);
        wait_k(57);  check("sr_r57", 32'(rst_out), 32'h0);
                     check("sr_rdy57", 32'(ready), 32'd1);

        // Lock loss in RUN
        wait_k(60);  locked = 1'b0;
        wait_k(62);  check("ll_r62", 32'(rst_out), 32'h0);
        wait_k(63);  check("ll_r63", 32'(rst_out), 32'hF);
                     check("ll_rdy63", 32'(ready), 32'd0);
                     check("ll_pll63", 32'(pll_rst), 32'd1);
`ifdef CLOCKS_RST_LOSS_CNT_EN
                     check("ll_cnt63", 32'(lock_loss_cnt), 32'd1);
`endif

        // Relock timeout
        wait_k(130); check("to_pll130", 32'(pll_rst), 32'd0);
        wait_k(131); check("to_pll131", 32'(pll_rst), 32'd1);
        wait_k(134); check("to_pll134", 32'(pll_rst), 32'd1);
        wait_k(135); check("to_pll135", 32'(pll_rst), 32'd0);
                     check("to_r135", 32'(rst_out), 32'hF);
`ifdef CLOCKS_RST_LOSS_CNT_EN
                     check("to_cnt135", 32'(lock_loss_cnt), 32'd2);
`endif

        // Glitch restarts the filter
        wait_k(140); locked = 1'b1;
        wait_k(145); locked = 1'b0;
        wait_k(146); locked = 1'b1;
        wait_k(159); check("gl_r159", 32'(rst_out), 32'hF);
        wait_k(160); check("gl_r160", 32'(rst_out), 32'hE);
        wait_k(172); check("gl_rdy172", 32'(ready), 32'd1);

        // Coincident lock loss and soft request: lock loss wins
        wait_k(180); locked = 1'b0;
        wait_k(182); soft_rst_req = 1'b1;
        wait_k(183); soft_rst_req = 1'b0;
                     locked = 1'b1;
                     check("co_pll183", 32'(pll_rst), 32'd1);
                     check("co_r183", 32'(rst_out), 32'hF);
        wait_k(187); check("co_r187", 32'(rst_out), 32'hF);
                     check("co_pll187", 32'(pll_rst), 32'd0);

        // Async reset partway through RELEASE
        wait_k(200); check("ar_r200", 32'(rst_out), 32'hE);
        async_reset_pulse("ar");

        // Randomised lock behaviour, soft requests and occasional async resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge refclk);
            soft_rst_req = ($urandom_range(0, 39) == 0);
            if (locked) begin
                if ($urandom_range(0, 59) == 0) locked = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                locked = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) begin
                soft_rst_req = 1'b0;
                async_reset_pulse("rnd_ar");
            end
        end
        @(negedge refclk);
        soft_rst_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
